// File: rtl/uart_tx_ctrl.sv
// uart_tx_ctrl: UART transmit controller FSM (start/data/parity/stop); define UART_TX_BACK2BACK_EN for gap-free back-to-back frames
module uart_tx_ctrl #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] P_DATA,
  input  logic                  DATA_VALID,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  output logic [1:0]            mux_sel,
  output logic                  ser_data,
  output logic                  par_bit,
  output logic                  busy
);
  localparam int CW = $clog2(DATA_WIDTH);
  localparam logic [CW-1:0] LAST = CW'(DATA_WIDTH - 1);
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
  state_t state, state_nx;
  logic [CW-1:0] cnt;
  logic [DATA_WIDTH-1:0] shreg;
  logic par_en_q;
  logic accept;
`ifdef UART_TX_BACK2BACK_EN
  assign accept = DATA_VALID && (state == IDLE || state == STOP);
`else
  assign accept = DATA_VALID && state == IDLE;
`endif
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = accept ? START : IDLE;
      START:   state_nx = DATA;
      DATA:    state_nx = cnt != LAST ? DATA : par_en_q ? PARITY : STOP;
      PARITY:  state_nx = STOP;
      STOP:    state_nx = accept ? START : IDLE;
      default: state_nx = IDLE;
    endcase
  end
  always_comb begin
    mux_sel  = state == START ? 2'b00 : state == DATA ? 2'b10 : state == PARITY ? 2'b11 : 2'b01;
    ser_data = state == DATA ? shreg[0] : 1'b1;
    busy     = state != IDLE;
  end
  // payload and parity config are only captured on acceptance, so they hold for the whole frame
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state    <= IDLE;
      cnt      <= '0;
      shreg    <= '0;
      par_en_q <= 1'b0;
      par_bit  <= 1'b0;
    end else begin
      state <= state_nx;
      cnt   <= state == DATA && cnt != LAST ? cnt + 1'b1 : '0;
      if (accept) begin
        shreg    <= P_DATA;
        par_en_q <= PAR_EN;
        par_bit  <= ^P_DATA ^ PAR_TYP;
      end else if (state == DATA) begin
        shreg <= shreg >> 1;
      end
    end
  end
endmodule
